program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Writer side of the instruction memory: fills a writable program RAM from a byte stream (boot/UART path).
//  Frame: 2-byte little-endian word count N, then 4*N data bytes, each word little-endian.
//  Emits word-aligned byte-address write strobes; the memory drops Address[1:0], as on the fetch side.
//  Sits between the byte receiver and the program RAM write port; holds the CPU off via Busy.
// PARAMETERS
//  MEMORY_DEPTH  32  words in the target program memory; upper bound on N
//  DATA_WIDTH    32  instruction/word width and byte-address width; fixed at 32 (4 byte lanes)
// PORTS
//  clk        in   1           single clock, rising edge
//  reset      in   1           synchronous, active-low
//  Start      in   1           1-cycle pulse: begin a frame (honoured only in IDLE/DONE/ERROR)
//  RxData     in   8           stream byte
//  RxValid    in   1           RxData valid
//  RxReady    out  1           loader accepts byte; transfer = RxValid & RxReady
//  WrEnable   out  1           1-cycle write strobe to program RAM
//  WrAddress  out  DATA_WIDTH  byte address, word aligned (word_index<<2), first word at 0
//  WrData     out  DATA_WIDTH  assembled word, byte0 -> [7:0]
//  Busy       out  1           frame in progress
//  Done       out  1           sticky: frame loaded OK; clears on Start or reset
//  Error      out  1           sticky: frame rejected; clears on Start or reset
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge): state IDLE; every output 0; lane/word counters and checksum 0.
//  - FSM: IDLE -Start-> LEN_LO -byte-> LEN_HI -byte-> DATA -last byte-> DONE.
//    After LEN_HI: N==0 -> DONE; N>MEMORY_DEPTH -> ERROR with no writes issued.
//  - RxReady=1 only in LEN_LO, LEN_HI, DATA (and CHECK); 0 in IDLE/DONE/ERROR and in the strobe cycle.
//  - DATA: 2-bit lane counter; 4th accepted byte completes the word. Next cycle: WrEnable=1 for
//    exactly one cycle, WrData/WrAddress valid with it; word index then increments. WrAddress/WrData
//    hold their last value when WrEnable=0.
//  - Done rises the cycle after the final WrEnable pulse (N==0: the cycle after LEN_HI accepted).
//  - Busy=1 in LEN_LO..CHECK, including the final strobe cycle; 0 in IDLE/DONE/ERROR.
//  - Start while Busy: ignored. Start in DONE/ERROR: clears flags, enters LEN_LO next cycle.
//  - Stalls: RxValid gaps of any length are legal; no timeout.
//  - Reset mid-frame: partial word discarded, no strobe; words already written stay in RAM.
//  - Counters never wrap: word index stops at N, so at most MEMORY_DEPTH strobes per frame.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after the last data byte, state CHECK accepts one extra byte.
//    It is compared with the running XOR of all data bytes (length bytes excluded).
//    Match -> DONE; mismatch -> ERROR. Words already written remain; Error marks the image invalid.
//    With N==0 the CHECK byte is still required and must equal 8'h00.
//  LOADER_CHECKSUM_EN undefined: no CHECK state, no checksum register; DATA -> DONE directly.
// STRUCTURE
//  - Shared package/include loader_defs: FSM state encodings (IDLE, LEN_LO, LEN_HI, DATA, CHECK,
//    DONE, ERROR), BYTES_PER_WORD=4, LEN_BYTES=2.
//  - One sub-module, word_assembler: 8->32 shifter plus lane counter. Outputs word_valid for 1 cycle.
//    Top level holds the FSM, word index, checksum and write-port registers.
// TESTING
//  1 Reset: hold reset=0 2 cycles with RxValid=1 -> all outputs 0, RxReady=0, no WrEnable.
//  2 Start; send 02 00 78 56 34 12 EF BE AD DE ->
//    WrEnable@addr 0 data 32'h12345678, @addr 4 data 32'hDEADBEEF; Done=1, Busy=0.
//  3 Start; send 21 00 (N=33 > 32) -> Error=1, zero WrEnable pulses, RxReady=0.
//  4 Start; send 01 00 11 22, reset=0 for 1 cycle, send 33 44 ->
//    no WrEnable, IDLE, flags 0; the bytes 33 44 are not accepted.
//  5 N=1 frame with RxValid toggling every other cycle and a Start mid-frame ->
//    single strobe data 32'h44332211 at addr 0; mid-frame Start ignored; Done.
//  6 LOADER_CHECKSUM_EN: N=1, bytes 11 22 33 44 then 44 -> Done (XOR=8'h44); trailer 45 -> Error.

Source files
------------

// File: rtl/loader_defs.sv
// Shared definitions for the program loader: FSM state encodings and frame geometry.
package loader_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;
  localparam int LEN_W          = 8 * LEN_BYTES;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into words; word_valid_o pulses with the final lane byte.
module word_assembler
  import loader_defs::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [WORD_W-9:0]   shreg_q, shreg_d;

  // The last lane is never stored: the word is completed combinationally from the incoming byte.
  assign word_o = {byte_i, shreg_q};

  always_comb begin
    lane_d       = lane_q;
    shreg_d      = shreg_q;
    word_valid_o = 1'b0;
    if (clear_i) begin
      lane_d = '0;
    end else if (byte_valid_i) begin
      if (lane_q == LANE_W'(BYTES_PER_WORD - 1)) begin
        word_valid_o = 1'b1;
        lane_d       = '0;
      end else begin
        shreg_d[{lane_q, 3'b000} +: 8] = byte_i;
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lane_q  <= '0;
      shreg_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream loader for the program RAM: length header, data words, optional XOR trailer.
// Build option LOADER_CHECKSUM_EN adds the CHECK state and the running-XOR checksum byte.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for Start after reset
// LEN_LO   | expecting word-count low byte
// LEN_HI   | expecting word-count high byte; range check on N
// DATA     | collecting data bytes; strobe cycle when a word completes
// CHECK    | expecting checksum trailer (checksum build only)
// DONE     | frame loaded; sticky until Start
// ERROR    | frame rejected; sticky until Start
module program_loader
  import loader_defs::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            RxData,
  input  logic                  RxValid,
  output logic                  RxReady,
  output logic                  WrEnable,
  output logic [DATA_WIDTH-1:0] WrAddress,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH + 1);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e ST_POST_DATA = ST_CHECK;
`else
  localparam state_e ST_POST_DATA = ST_DONE;
`endif

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif

  logic                  accept;
  logic                  asm_clear;
  logic                  asm_valid;
  logic                  word_valid;
  logic [WORD_W-1:0]     word;
  logic [LEN_W-1:0]      n_len;

  // The strobe cycle back-pressures the receiver so a word never overlaps its own write.
  assign RxReady   = !wr_en_q &&
                     (state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK});
  assign accept    = RxValid && RxReady;
  assign asm_valid = accept && (state_q == ST_DATA);
  assign n_len     = {RxData, len_q[7:0]};

  assign Busy      = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK};
  assign Done      = (state_q == ST_DONE);
  assign Error     = (state_q == ST_ERROR);
  assign WrEnable  = wr_en_q;
  assign WrAddress = wr_addr_q;
  assign WrData    = wr_data_q;

  word_assembler u_asm (
    .clk_i        (clk),
    .rst_ni       (reset),
    .clear_i      (asm_clear),
    .byte_i       (RxData),
    .byte_valid_i (asm_valid),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    asm_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          state_d   = ST_LEN_LO;
          len_d     = '0;
          idx_d     = '0;
          asm_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          chk_d     = '0;
`endif
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = RxData;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = n_len;
          if (n_len == '0)
            state_d = ST_POST_DATA;
          else if (n_len > LEN_W'(MEMORY_DEPTH))
            state_d = ST_ERROR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Index has already advanced during the strobe, so equality with N marks the last word.
        if (wr_en_q && (len_q == LEN_W'(idx_q))) begin
          state_d = ST_POST_DATA;
        end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          chk_d = chk_q ^ RxData;
`endif
          if (word_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = DATA_WIDTH'({idx_q, 2'b00});
            wr_data_d = DATA_WIDTH'(word);
            idx_d     = idx_q + IDX_W'(1);
          end
        end
      end
      ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept)
          state_d = (RxData == chk_q) ? ST_DONE : ST_ERROR;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame table plus hand-written multi-cycle sequences.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic        WrEnable;
  logic [31:0] WrAddress;
  logic [31:0] WrData;
  logic        Busy;
  logic        Done;
  logic        Error;

  always #5 clk = ~clk;

  program_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .RxReady   (RxReady),
    .WrEnable  (WrEnable),
    .WrAddress (WrAddress),
    .WrData    (WrData),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  typedef struct {
    int          n;
    logic [7:0]  b[10];
    int          nw;
    logic [31:0] w[2];
    logic        done;
    logic        err;
  } vec_t;

  vec_t        vt[6];
  int          nvec = 0;
  int          nerr = 0;
  int          viol = 0;
  logic        prev_we = 1'b0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  chk;

  // Write-port monitor: records every strobe and flags strobe-rule breaches.
  initial begin
    forever begin
      @(negedge clk);
      if (WrEnable === 1'b1) begin
        obs_q.push_back({WrAddress, WrData});
        if (RxReady !== 1'b0) viol++;
        if (prev_we) viol++;
      end
      prev_we = (WrEnable === 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    RxData  = b;
    RxValid = 1'b1;
    while (!RxReady && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!RxReady) begin
      nvec++;
      nerr++;
      $display("FAIL rx_timeout: byte %h not accepted, got RxReady=0, expected 1", b);
      RxValid = 1'b0;
    end else begin
      @(negedge clk);
      RxValid = 1'b0;
    end
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (Busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (Busy) begin
      nvec++;
      nerr++;
      $display("FAIL %s_busy_timeout: got Busy=1, expected 0", tag);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [63:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL %s_missing_write: got none, expected addr %h data %h", tag, e[63:32], e[31:0]);
      end else begin
        o = obs_q.pop_front();
        check({tag, "_waddr"}, o[63:32], e[63:32]);
        check({tag, "_wdata"}, o[31:0], e[31:0]);
      end
    end
    check({tag, "_extra_writes"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic run_vec(input int k);
    string tag;
    tag = $sformatf("vec%0d", k);
    start_pulse();
    check({tag, "_start_busy"}, {Busy, Done, Error}, 3'b100);
    for (int j = 0; j < vt[k].nw; j++)
      exp_q.push_back({32'(j * 4), vt[k].w[j]});
    chk = 8'h00;
    for (int i = 0; i < vt[k].n; i++) begin
      if (i >= 2) chk = chk ^ vt[k].b[i];
      send_byte(vt[k].b[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    if (!vt[k].err) send_byte(chk);
`endif
    wait_idle(tag);
    check({tag, "_flags"}, {Busy, Done, Error, RxReady}, {1'b0, vt[k].done, vt[k].err, 1'b0});
    check_writes(tag);
  endtask

  initial begin
    vt[0].n = 10; vt[0].b = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    vt[0].nw = 2; vt[0].w = '{32'h12345678, 32'hDEADBEEF}; vt[0].done = 1; vt[0].err = 0;
    vt[1].n = 2;  vt[1].b = '{8'h21, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1].nw = 0; vt[1].w = '{0, 0}; vt[1].done = 0; vt[1].err = 1;
    vt[2].n = 2;  vt[2].b = '{8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[2].nw = 0; vt[2].w = '{0, 0}; vt[2].done = 1; vt[2].err = 0;
    vt[3].n = 2;  vt[3].b = '{8'h01, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3].nw = 0; vt[3].w = '{0, 0}; vt[3].done = 0; vt[3].err = 1;
    vt[4].n = 6;  vt[4].b = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0};
    vt[4].nw = 1; vt[4].w = '{32'h44332211, 0}; vt[4].done = 1; vt[4].err = 0;
    vt[5].n = 6;  vt[5].b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 0, 0, 0, 0};
    vt[5].nw = 1; vt[5].w = '{32'h80000000, 0}; vt[5].done = 1; vt[5].err = 0;

    reset = 1'b0; Start = 1'b0; RxValid = 1'b1; RxData = 8'hA5;
    repeat (2) @(negedge clk);
    check("reset_outputs", {RxReady, WrEnable, Busy, Done, Error}, 5'b0);
    check("reset_waddr", WrAddress, 32'h0);
    check("reset_wdata", WrData, 32'h0);
    check("reset_no_writes", obs_q.size(), 0);
    RxValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(k);

`ifndef LOADER_CHECKSUM_EN
    // Strobe and Done timing around the final word.
    start_pulse();
    exp_q.push_back({32'h0, 32'h12345678});
    exp_q.push_back({32'h4, 32'hDEADBEEF});
    for (int i = 0; i < 10; i++) send_byte(vt[0].b[i]);
    check("final_strobe", {WrEnable, Busy, Done}, 3'b110);
    check("final_strobe_addr", WrAddress, 32'h4);
    @(negedge clk);
    check("done_after_strobe", {WrEnable, Busy, Done, Error}, 4'b0010);
    check("hold_waddr", WrAddress, 32'h4);
    check("hold_wdata", WrData, 32'hDEADBEEF);
    check_writes("timing");
`endif

    // Largest legal frame: N == MEMORY_DEPTH.
    start_pulse();
    send_byte(8'h20);
    send_byte(8'h00);
    chk = 8'h00;
    for (int j = 0; j < 32; j++) begin
      logic [31:0] w;
      w = {8'(j), 8'hA5, 8'h5A, ~8'(j)};
      exp_q.push_back({32'(j * 4), w});
      for (int l = 0; l < 4; l++) begin
        chk = chk ^ w[l*8 +: 8];
        send_byte(w[l*8 +: 8]);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(chk);
`endif
    wait_idle("full");
    check("full_flags", {Done, Error}, 2'b10);
    check_writes("full");

    // Reset in the middle of a word.
    start_pulse();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midreset_outputs", {RxReady, WrEnable, Busy, Done, Error}, 5'b0);
    check("midreset_waddr", WrAddress, 32'h0);
    RxValid = 1'b1;
    RxData  = 8'h33;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        if (RxReady) seen++;
        @(negedge clk);
        RxData = 8'h44;
      end
      check("midreset_bytes_refused", seen, 0);
    end
    RxValid = 1'b0;
    check("midreset_idle", {Busy, Done, Error}, 3'b000);
    check_writes("midreset");

    // Stalled stream with an ignored Start mid-frame.
    start_pulse();
    exp_q.push_back({32'h0, 32'h44332211});
    send_byte(8'h01); @(negedge clk);
    send_byte(8'h00); @(negedge clk);
    send_byte(8'h11); @(negedge clk);
    start_pulse();
    check("midstart_ignored", {Busy, Done, Error}, 3'b100);
    send_byte(8'h22); @(negedge clk);
    send_byte(8'h33); @(negedge clk);
    send_byte(8'h44); @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    wait_idle("stall");
    check("stall_flags", {Done, Error}, 2'b10);
    check_writes("stall");

`ifdef LOADER_CHECKSUM_EN
    // Trailer mismatch: the word is still written but the frame is rejected.
    start_pulse();
    exp_q.push_back({32'h0, 32'h44332211});
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h45);
    wait_idle("badchk");
    check("badchk_flags", {Done, Error}, 2'b01);
    check_writes("badchk");
`endif

    check("strobe_rules", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
